// File: rtl/vlsu_store_wb_tracker.sv
// rtl/vlsu_store_wb_tracker.sv - store write-path tracker: W beat buffer, AW/B accounting, per-instruction completion
// W beats wait in a small FIFO until their AW is out; B responses are folded into one done/err per store instruction.
module vlsu_store_wb_tracker #(
   parameter int AxiDataWidth   = 128,
   parameter int WDepth         = 4,
   parameter int MaxOutstanding = 8,
   parameter int BurstCntWidth  = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      s_w_valid_i,
   output logic                      s_w_ready_o,
   input  logic [AxiDataWidth-1:0]   s_w_data_i,
   input  logic [AxiDataWidth/8-1:0] s_w_strb_i,
   input  logic                      s_w_last_i,
   output logic                      m_w_valid_o,
   input  logic                      m_w_ready_i,
   output logic [AxiDataWidth-1:0]   m_w_data_o,
   output logic [AxiDataWidth/8-1:0] m_w_strb_o,
   output logic                      m_w_last_o,
   input  logic                      aw_fire_i,
   output logic                      aw_credit_o,
   input  logic                      m_b_valid_i,
   output logic                      m_b_ready_o,
   input  logic [1:0]                m_b_resp_i,
   input  logic                      insn_valid_i,
   output logic                      insn_ready_o,
   input  logic [BurstCntWidth-1:0]  insn_bursts_i,
   output logic                      done_valid_o,
   input  logic                      done_ready_i,
   output logic                      done_err_o,
   output logic                      proto_err_o
);

   localparam int StrbWidth = AxiDataWidth / 8;
   localparam int PtrWidth  = (WDepth > 1) ? $clog2(WDepth) : 1;
   localparam int FillWidth = $clog2(WDepth + 1);
   localparam int CntWidth  = $clog2(MaxOutstanding + 1);
   localparam int SumWidth  = CntWidth + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DONE
   } state_t;

   logic [AxiDataWidth-1:0] data_mem [WDepth];
   logic [StrbWidth-1:0]    strb_mem [WDepth];
   logic [WDepth-1:0]       last_mem;
   logic [PtrWidth-1:0]     wr_ptr;
   logic [PtrWidth-1:0]     rd_ptr;
   logic [FillWidth-1:0]    fill;

   logic [CntWidth-1:0]     aw_cnt;
   logic [CntWidth-1:0]     ob_cnt;
   logic [CntWidth-1:0]     aw_nxt;
   logic [CntWidth-1:0]     ob_nxt;
   logic [SumWidth-1:0]     inflight;
   logic [SumWidth-1:0]     inflight_nxt;

   logic fifo_empty;
   logic fifo_full;
   logic w_push;
   logic w_pop;
   logic w_last_pop;
   logic b_fire;
   logic aw_over;
   logic b_under;

   state_t                   state;
   logic [BurstCntWidth-1:0] remaining;
   logic                     err;
   logic                     unused_resp_ok;

   assign fifo_empty  = (fill == '0);
   assign fifo_full   = (fill == FillWidth'(WDepth));
   assign s_w_ready_o = !fifo_full;
   assign w_push      = s_w_valid_i && !fifo_full;

   // Only the first beat of a burst can be held here: aw_cnt stays non-zero until its last beat leaves.
   assign m_w_valid_o = !fifo_empty && (aw_cnt != '0);
   assign w_pop       = m_w_valid_o && m_w_ready_i;
   assign w_last_pop  = w_pop && m_w_last_o;

   assign m_w_data_o  = data_mem[rd_ptr];
   assign m_w_strb_o  = strb_mem[rd_ptr];
   assign m_w_last_o  = last_mem[rd_ptr];

   assign b_fire         = m_b_valid_i && m_b_ready_o;
   assign inflight       = SumWidth'(aw_cnt) + SumWidth'(ob_cnt);
   assign aw_over        = aw_fire_i && (inflight >= SumWidth'(MaxOutstanding));
   assign b_under        = b_fire && (ob_cnt == '0);
   assign unused_resp_ok = m_b_resp_i[0];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         data_mem[wr_ptr] <= s_w_data_i;
         strb_mem[wr_ptr] <= s_w_strb_i;
         last_mem[wr_ptr] <= s_w_last_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (w_push) begin
            wr_ptr <= (wr_ptr == PtrWidth'(WDepth - 1)) ? '0 : wr_ptr + PtrWidth'(1);
         end
         if (w_pop) begin
            rd_ptr <= (rd_ptr == PtrWidth'(WDepth - 1)) ? '0 : rd_ptr + PtrWidth'(1);
         end
         if (w_push && !w_pop) begin
            fill <= fill + FillWidth'(1);
         end else if (!w_push && w_pop) begin
            fill <= fill - FillWidth'(1);
         end
      end
   end

   // A burst moves from aw_cnt to ob_cnt when its last beat leaves, so the in-flight sum is unchanged by that move.
   always_comb begin
      aw_nxt = aw_cnt;
      ob_nxt = ob_cnt;
      if (aw_fire_i && !aw_over) begin
         aw_nxt = aw_nxt + CntWidth'(1);
      end
      if (w_last_pop) begin
         aw_nxt = aw_nxt - CntWidth'(1);
         ob_nxt = ob_nxt + CntWidth'(1);
      end
      if (b_fire && !b_under) begin
         ob_nxt = ob_nxt - CntWidth'(1);
      end
      inflight_nxt = SumWidth'(aw_nxt) + SumWidth'(ob_nxt);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_cnt      <= '0;
         ob_cnt      <= '0;
         aw_credit_o <= 1'b1;
         proto_err_o <= 1'b0;
      end else begin
         aw_cnt      <= aw_nxt;
         ob_cnt      <= ob_nxt;
         aw_credit_o <= (inflight_nxt < SumWidth'(MaxOutstanding));
         if (aw_over || b_under) begin
            proto_err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         remaining    <= '0;
         err          <= 1'b0;
         insn_ready_o <= 1'b1;
         m_b_ready_o  <= 1'b0;
         done_valid_o <= 1'b0;
         done_err_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (insn_valid_i && insn_ready_o) begin
                  remaining    <= insn_bursts_i;
                  err          <= 1'b0;
                  insn_ready_o <= 1'b0;
                  if (insn_bursts_i == '0) begin
                     state        <= ST_DONE;
                     done_valid_o <= 1'b1;
                     done_err_o   <= 1'b0;
                  end else begin
                     state       <= ST_COUNT;
                     m_b_ready_o <= 1'b1;
                  end
               end
            end
            ST_COUNT: begin
               if (b_fire) begin
                  remaining <= remaining - BurstCntWidth'(1);
                  err       <= err | m_b_resp_i[1];
                  if (remaining == BurstCntWidth'(1)) begin
                     state        <= ST_DONE;
                     m_b_ready_o  <= 1'b0;
                     done_valid_o <= 1'b1;
                     done_err_o   <= err | m_b_resp_i[1];
                  end
               end
            end
            ST_DONE: begin
               if (done_ready_i) begin
                  state        <= ST_IDLE;
                  done_valid_o <= 1'b0;
                  done_err_o   <= 1'b0;
                  insn_ready_o <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/vlsu_store_wb_tracker.md
Name: vlsu_store_wb_tracker

Overview:
- Sits directly downstream of the store unit's AXI W output and in front of the AXI master port.
- Buffers W beats and releases a burst only after its AW has been issued.
- Counts bursts outstanding for a B response, issues AW credits to the address generator, and aggregates B responses per store instruction into one completion/error handshake toward the dispatcher.

Parameters:
- AxiDataWidth, 128, W data width in bits; strobe width is AxiDataWidth/8.
- WDepth, 4, W beat FIFO depth (>=2).
- MaxOutstanding, 8, max bursts with AW issued but B not yet received.
- BurstCntWidth, 16, width of the per-instruction burst count.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_w_valid_i  in  1  W beat from store unit
- s_w_ready_o  out  1  beat accepted
- s_w_data_i  in  AxiDataWidth  data
- s_w_strb_i  in  AxiDataWidth/8  strobe
- s_w_last_i  in  1  last beat of burst
- m_w_valid_o  out  1  W beat to AXI master
- m_w_ready_i  in  1  master ready
- m_w_data_o  out  AxiDataWidth  data
- m_w_strb_o  out  AxiDataWidth/8  strobe
- m_w_last_o  out  1  last beat
- aw_fire_i  in  1  AW handshake occurred at master port this cycle
- aw_credit_o  out  1  address generator may issue another AW
- m_b_valid_i  in  1  B response valid
- m_b_ready_o  out  1  B accepted
- m_b_resp_i  in  2  BRESP
- insn_valid_i  in  1  new store instruction
- insn_ready_o  out  1  tracker free
- insn_bursts_i  in  BurstCntWidth  bursts in instruction
- done_valid_o  out  1  instruction complete
- done_ready_i  in  1  completion consumed
- done_err_o  out  1  any SLVERR/DECERR in instruction
- proto_err_o  out  1  sticky protocol violation

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values (registered, valid the cycle after rst_i is sampled high):
  - FIFO empty; all counters 0; FSM IDLE.
  - m_w_valid_o=0, m_b_ready_o=0, done_valid_o=0, done_err_o=0, proto_err_o=0.
  - s_w_ready_o=1, insn_ready_o=1, aw_credit_o=1.
- Reset mid-operation discards buffered beats and all counts.
- W FIFO:
  - s_w_ready_o = !full. No same-cycle bypass: a pushed beat is visible at the head the next cycle, so minimum latency is 1 cycle.
  - Push and pop in the same cycle are allowed whenever the FIFO is non-full and non-empty.
  - m_w_data_o, m_w_strb_o and m_w_last_o are driven from the FIFO head.
- AW gating (aw_cnt, range 0..MaxOutstanding):
  - +1 on aw_fire_i; -1 on a master W handshake with last=1; simultaneous increment and decrement leaves it unchanged.
  - m_w_valid_o = !empty && aw_cnt>0. The decision uses the registered aw_cnt, so an AW fired in cycle N releases W in cycle N+1.
  - Once the first beat of a burst is sent, the following beats are not re-gated, since aw_cnt stays >0 until last.
- Outstanding-B counter (ob_cnt):
  - +1 on a master W last handshake; -1 on a B handshake.
  - aw_credit_o = (aw_cnt + ob_cnt) < MaxOutstanding, registered.
- proto_err_o (sticky until reset) is set when any of the following occurs:
  - aw_fire_i arrives while aw_cnt+ob_cnt == MaxOutstanding; the count saturates.
  - A B handshake occurs with ob_cnt==0; the counter is held at 0.
- Instruction FSM:
  - IDLE: insn_ready_o=1. On insn handshake, load remaining=insn_bursts_i and clear err. Go to DONE if insn_bursts_i==0, else to COUNT.
  - COUNT: m_b_ready_o=1, insn_ready_o=0. Each B handshake decrements remaining and ORs m_b_resp_i[1] into err (EXOKAY counts as OK). A B handshake with remaining==1 goes to DONE.
  - DONE: done_valid_o=1, done_err_o=err, held stable until done_ready_i. On handshake go to IDLE; insn_ready_o rises the following cycle.
  - m_b_ready_o=0 in IDLE and DONE: B responses stall and are never dropped.
- W forwarding and AW credit run independently of the FSM, so bursts of the next instruction may flow while the current one is in DONE.

Test Plan:
- AW gating: insn_bursts=1; push 4 beats (last on beat 4) at cycles 1-4; aw_fire_i at cycle 10 -> m_w_valid_o=0 through cycle 10, beats out cycles 11-14; B OKAY at 16 -> done_valid_o=1 at 17 with done_err_o=0.
- FIFO backpressure: WDepth=4, aw_fire_i given, m_w_ready_i=0, 6 beats offered -> 4 accepted, s_w_ready_o=0 while full; m_w_ready_i=1 -> all 6 beats delivered in order, data/strb intact.
- Error aggregation: insn_bursts=3, BRESP OKAY, SLVERR, OKAY -> done_valid_o only after the third B, done_err_o=1; next instruction with all OKAY -> done_err_o=0.
- Zero-burst instruction: insn_bursts=0 -> done_valid_o=1 the next cycle; m_b_ready_o never asserted; a pending B stalls until the next COUNT.
- Credit limit: MaxOutstanding=2; 2 aw_fire_i pulses, no B -> aw_credit_o=0; one B -> aw_credit_o=1 the next cycle; a third aw_fire_i while aw_credit_o=0 -> proto_err_o=1.
- Reset mid-burst: 2 of 4 beats forwarded, rst_i pulsed -> m_w_valid_o=0, FIFO empty, FSM IDLE, s_w_ready_o/insn_ready_o/aw_credit_o=1, proto_err_o=0.
